// File: rtl/stoch_l2_norm_sched.sv
// Round-robin scheduler that time-shares one signed stochastic L2-norm datapath.
// Each job clears the datapath, warms it up, then integrates yp-yn over a window.
module stoch_l2_norm_sched #(
  parameter int NUM_REQ = 4,
  parameter int VEC_LEN = 2,
  parameter int WARMUP  = 64,
  parameter int WINDOW  = 256,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int RES_W   = $clog2(WINDOW+1)+1
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*VEC_LEN-1:0]   up_in,
  input  logic [NUM_REQ*VEC_LEN-1:0]   un_in,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         dp_nrst,
  output logic [VEC_LEN-1:0]           dp_up,
  output logic [VEC_LEN-1:0]           dp_un,
  input  logic                         dp_yp,
  input  logic                         dp_yn,
  output logic                         busy,
  output logic                         done,
  output logic [ID_W-1:0]              done_id,
  output logic signed [RES_W-1:0]      result
);

  localparam int MAXC  = (WARMUP > WINDOW) ? WARMUP : WINDOW;
  localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [2:0] {
    IDLE, CLEAR, WARM, MEAS, DONE
  } state_t;

  state_t                   state, state_n;
  logic [ID_W-1:0]          rr, idx, sel, idx_nxt;
  logic [CNT_W-1:0]         cnt;
  logic signed [RES_W-1:0]  acc, delta, acc_nxt;
  logic [2*NUM_REQ-1:0]     req_rot;
  logic                     any_req, own_req;
  logic                     cnt_zero, stream_en;
  int                       sel_i;

  // Rotating by rr makes bit 0 the highest-priority candidate.
  assign req_rot = {req, req} >> rr;

  always_comb begin
    any_req = 1'b0;
    sel_i   = 0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      if (req_rot[k]) begin
        any_req = 1'b1;
        sel_i   = int'(rr) + k;
      end
    end
    if (sel_i >= NUM_REQ) sel_i = sel_i - NUM_REQ;
    sel = ID_W'(sel_i);
  end

  assign idx_nxt   = (idx == ID_W'(NUM_REQ-1)) ? '0
                                               : idx + ID_W'(1);
  assign own_req   = |(req & grant);
  assign cnt_zero  = (cnt == '0);
  assign stream_en = (state == WARM) || (state == MEAS);

  always_comb begin
    delta = '0;
    unique case ({dp_yp, dp_yn})
      2'b10:   delta = RES_W'(1);
      2'b01:   delta = '1;
      default: delta = '0;
    endcase
  end

  assign acc_nxt = acc + delta;

  always_comb begin
    dp_up = '0;
    dp_un = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (stream_en && grant[i]) begin
        dp_up = dp_up | up_in[i*VEC_LEN +: VEC_LEN];
        dp_un = dp_un | un_in[i*VEC_LEN +: VEC_LEN];
      end
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (any_req) state_n = CLEAR;
      CLEAR: state_n = own_req ? WARM : IDLE;
      WARM: begin
        if (!own_req)     state_n = IDLE;
        else if (cnt_zero) state_n = MEAS;
      end
      MEAS: begin
        if (!own_req)     state_n = IDLE;
        else if (cnt_zero) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rr      <= '0;
      idx     <= '0;
      grant   <= '0;
      cnt     <= '0;
      acc     <= '0;
      result  <= '0;
      done_id <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            grant <= NUM_REQ'(1) << sel;
            idx   <= sel;
          end
        end
        CLEAR: begin
          if (!own_req) begin
            grant <= '0;
            rr    <= idx_nxt;
          end else begin
            cnt <= CNT_W'(WARMUP-1);
          end
        end
        WARM: begin
          if (!own_req) begin
            grant <= '0;
            rr    <= idx_nxt;
          end else if (cnt_zero) begin
            cnt <= CNT_W'(WINDOW-1);
            acc <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        MEAS: begin
          if (!own_req) begin
            grant <= '0;
            rr    <= idx_nxt;
          end else begin
            acc <= acc_nxt;
            if (cnt_zero) begin
              result  <= acc_nxt;
              done_id <= idx;
              grant   <= '0;
              rr      <= idx_nxt;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
        end
        DONE:    begin end
        default: begin end
      endcase
    end
  end

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign dp_nrst = nRST & (state != CLEAR);

endmodule

// File: tb/tb_stoch_l2_norm_sched.sv
// Directed bench for stoch_l2_norm_sched with WARMUP=4, WINDOW=8.
// Jobs are replayed cycle by cycle against a hand-derived timeline.
module tb_stoch_l2_norm_sched;

  localparam int NR  = 4;
  localparam int VL  = 2;
  localparam int WU  = 4;
  localparam int WN  = 8;
  localparam int IDW = 2;
  localparam int RW  = 5;

  logic                 CLK = 1'b0;
  logic                 nRST = 1'b0;
  logic [NR-1:0]        req;
  logic [NR*VL-1:0]     up_in = 8'b01_11_10_01;
  logic [NR*VL-1:0]     un_in = 8'b10_01_11_10;
  logic [NR-1:0]        grant;
  logic                 dp_nrst;
  logic [VL-1:0]        dp_up, dp_un;
  logic                 dp_yp, dp_yn;
  logic                 busy, done;
  logic [IDW-1:0]       done_id;
  logic signed [RW-1:0] result;

  int errs = 0;
  int checks = 0;

  typedef struct {
    logic [NR-1:0] req;
    int            mode;
    int            res;
    int            id;
  } vec_t;

  vec_t tbl[6];

  stoch_l2_norm_sched #(
    .NUM_REQ(NR), .VEC_LEN(VL), .WARMUP(WU), .WINDOW(WN)
  ) dut (
    .CLK(CLK), .nRST(nRST), .req(req),
    .up_in(up_in), .un_in(un_in), .grant(grant),
    .dp_nrst(dp_nrst), .dp_up(dp_up), .dp_un(dp_un),
    .dp_yp(dp_yp), .dp_yn(dp_yn), .busy(busy),
    .done(done), .done_id(done_id), .result(result)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm,
                     input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // k counts cycles after the IDLE request cycle: 1=CLEAR, 2..5 WARM,
  // 6..13 MEAS, 14 DONE.
  task automatic drive(input int mode, input int k);
    int m;
    m = k - 6;
    dp_yp = 1'b1;
    dp_yn = 1'b0;
    case (mode)
      1: if (m >= 0 && m < WN) begin
           dp_yp = (m % 2 == 0);
           dp_yn = (m % 2 == 1);
         end
      2: begin
           dp_yp = 1'b0;
           dp_yn = (k >= 2 && k <= 5) || (m >= 0 && m < 3);
         end
      3: begin
           dp_yp = 1'b0;
           dp_yn = 1'b1;
         end
      default: ;
    endcase
  endtask

  task automatic run_job(input logic [NR-1:0] r, input int mode,
                         input int res, input int id,
                         input string nm);
    logic [NR*VL-1:0] su, sn;
    logic [NR-1:0]    eg;
    logic             strm;
    req = r;
    drive(mode, 0);
    su = up_in >> (id*VL);
    sn = un_in >> (id*VL);
    for (int k = 1; k <= 14; k++) begin
      @(negedge CLK);
      eg   = (k <= 13) ? NR'(1 << id) : '0;
      strm = (k >= 2 && k <= 13);
      chk({nm, ".grant"}, grant, eg);
      chk({nm, ".dp_nrst"}, dp_nrst, (k != 1));
      chk({nm, ".busy"}, busy, 1);
      chk({nm, ".done"}, done, (k == 14));
      chk({nm, ".dp_up"}, dp_up, strm ? su[VL-1:0] : '0);
      chk({nm, ".dp_un"}, dp_un, strm ? sn[VL-1:0] : '0);
      if (k == 14) begin
        chk({nm, ".result"}, result, res);
        chk({nm, ".done_id"}, done_id, id);
      end
      drive(mode, k);
    end
  endtask

  initial begin
    req   = '0;
    dp_yp = 1'b0;
    dp_yn = 1'b0;

    tbl[0] = '{4'b0001, 0,  8, 0};
    tbl[1] = '{4'b0001, 1,  0, 0};
    tbl[2] = '{4'b0001, 2, -3, 0};
    tbl[3] = '{4'b1000, 3, -8, 3};
    tbl[4] = '{4'b0110, 0,  8, 1};
    tbl[5] = '{4'b0011, 2, -3, 0};

    repeat (2) @(negedge CLK);
    chk("rst.grant", grant, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.dp_nrst", dp_nrst, 0);
    chk("rst.result", result, 0);
    chk("rst.done_id", done_id, 0);
    chk("rst.dp_up", dp_up, 0);
    nRST = 1'b1;
    @(negedge CLK);

    // All requesters held: rotation 0,1,2,3,0 with an IDLE gap each time.
    for (int i = 0; i < 5; i++) begin
      run_job(4'b1111, 0, 8, i % NR, "rr");
      @(negedge CLK);
      chk("rr.idle_busy", busy, 0);
      chk("rr.idle_grant", grant, 0);
    end

    for (int i = 0; i < 6; i++) begin
      run_job(tbl[i].req, tbl[i].mode, tbl[i].res, tbl[i].id,
              $sformatf("tbl%0d", i));
      req = '0;
      @(negedge CLK);
    end

    // Abort: requester 1 drops its request in the fourth MEAS cycle.
    req = 4'b0010;
    drive(0, 0);
    for (int k = 1; k <= 9; k++) begin
      @(negedge CLK);
      drive(0, k);
      if (k == 9) begin
        chk("abort.grant_meas", grant, 4'b0010);
        req = '0;
      end
    end
    @(negedge CLK);
    chk("abort.busy", busy, 0);
    chk("abort.grant", grant, 0);
    chk("abort.done", done, 0);
    chk("abort.result", result, -3);
    chk("abort.done_id", done_id, 0);
    run_job(4'b0011, 0, 8, 0, "abort_next");
    req = '0;
    @(negedge CLK);

    // Asynchronous reset in the middle of warm-up.
    req = 4'b0100;
    drive(0, 0);
    repeat (3) @(negedge CLK);
    chk("warm.busy", busy, 1);
    chk("warm.grant", grant, 4'b0100);
    nRST = 1'b0;
    #1;
    chk("arst.grant", grant, 0);
    chk("arst.busy", busy, 0);
    chk("arst.dp_nrst", dp_nrst, 0);
    chk("arst.result", result, 0);
    chk("arst.done_id", done_id, 0);
    chk("arst.dp_up", dp_up, 0);
    @(negedge CLK);
    nRST = 1'b1;
    run_job(4'b0100, 0, 8, 2, "post_rst");
    req = '0;
    @(negedge CLK);
    chk("end.busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/stoch_l2_norm_sched.md
Name: stoch_l2_norm_sched

Overview:
Time-shares one signed stochastic L2-norm datapath among NUM_REQ requesters. Each requester presents a signed bitstream vector pair (up/un). The block grants the datapath round-robin and clears the datapath's internal state with a local reset pulse. It then waits a warm-up period while the decorrelator and square-root stages settle, and integrates the datapath output over a fixed measurement window. The result is returned as a signed count with a done pulse tagged with the requester index.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
VEC_LEN, 2, vector length per requester; matches the datapath
WARMUP, 64, cycles discarded after datapath clear (>=1)
WINDOW, 256, measurement cycles integrated (>=1)
ID_W, $clog2(NUM_REQ), width of requester index (derived)
RES_W, $clog2(WINDOW+1)+1, signed result width (derived)

Ports:
CLK  in  1  clock, all state updates on rising edge
nRST  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester job request; level, held until done or abort
up_in  in  NUM_REQ*VEC_LEN  positive bitstreams, requester i at [i*VEC_LEN +: VEC_LEN]
un_in  in  NUM_REQ*VEC_LEN  negative bitstreams, same packing
grant  out  NUM_REQ  one-hot owner of datapath, zero when unowned
dp_nrst  out  1  active-low clear to datapath nRST, ANDed with nRST
dp_up  out  VEC_LEN  muxed positive stream to datapath
dp_un  out  VEC_LEN  muxed negative stream to datapath
dp_yp  in  1  datapath positive output stream
dp_yn  in  1  datapath negative output stream
busy  out  1  state != IDLE
done  out  1  single-cycle result-valid pulse
done_id  out  ID_W  requester index of completed job, held until next done
result  out  RES_W  signed sum(dp_yp) - sum(dp_yn) over window, held until next done

Behaviour:
- Reset (nRST=0, async): state=IDLE, rr pointer=0, grant=0, done=0, done_id=0, result=0, counters=0, busy=0. dp_nrst=0 while nRST=0.
- FSM states: IDLE, CLEAR, WARM, MEAS, DONE.
- IDLE: if any req, pick the first set bit at or after rr pointer (circular). Register grant and go to CLEAR next cycle. If no req, stay.
- CLEAR: exactly 1 cycle. dp_nrst=0, dp_up/dp_un=0. Load the phase counter with WARMUP-1 and go to WARM.
- WARM: WARMUP cycles. dp_up/dp_un = granted requester's streams (combinational mux on grant). dp_yp/dp_yn are ignored. On the counter reaching 0, load WINDOW-1, clear the accumulator, go to MEAS.
- MEAS: WINDOW cycles, same muxing. Each cycle acc += dp_yp - dp_yn (both 1 means no change). On the counter reaching 0, go to DONE; that cycle's sample is included.
- DONE: 1 cycle. done=1, result=final acc, done_id=granted index, grant cleared. rr pointer = granted index+1 mod NUM_REQ. Next state IDLE.
- Latency: if req is first seen in IDLE at cycle t, done=1 at cycle t+2+WARMUP+WINDOW.
- Back-to-back: a requester still asserting req in IDLE after its DONE competes normally. Round-robin ensures another pending requester wins first.
- Abort: if the granted requester's req drops in CLEAR, WARM or MEAS, go to IDLE next cycle. No done is issued, result and done_id are unchanged, grant is cleared, and rr pointer advances past the aborted index.
- Requests from non-granted requesters are ignored while busy. They must remain asserted to be served.
- dp_up/dp_un are 0 in IDLE, CLEAR and DONE.
- Accumulator range is -WINDOW..+WINDOW; RES_W guarantees no overflow.
- Reset mid-operation: immediate return to reset values. The partial job is discarded.

Test Plan:
- WARMUP=4, WINDOW=8. req=0001, dp_yp tied 1, dp_yn tied 0 -> CLEAR at t+1, done at t+14, result=8, done_id=0.
- Same params, dp_yp=1 and dp_yn=1 on alternate MEAS cycles, with dp_yp=1 throughout WARM -> result=0. Additionally forcing dp_yn=1 only during the first 3 MEAS cycles with dp_yp=0 throughout -> result=-3 (WARM samples ignored).
- req=1111 held continuously -> done_id sequence 0,1,2,3,0. grant is always one-hot and changes only via IDLE. dp_up equals the selected up_in slice in WARM/MEAS and 0 elsewhere.
- req=0010 granted, req[1] dropped on MEAS cycle 3 -> no done pulse, state IDLE next cycle, result and done_id retain previous values. A following req=0011 grants requester 0 before 1 only if rr wrapped; with rr=2 it grants requester 0 first (next set bit circularly).
- nRST pulsed low during WARM -> grant=0, busy=0, dp_nrst=0 immediately (async). After release, req=0100 completes normally with the correct result.
- dp_nrst low for exactly one cycle per job (CLEAR). Check dp_nrst = nRST & ~(state==CLEAR).
